gcd_scheduler: RTL and testbench
================================

Name: gcd_scheduler

Overview:
- Sequences a single shared subtractive-GCD datapath (registers A/B, subtractor, comparator) and time-shares it among NREQ requesters.
- Round-robin arbitration picks one requester. The block loads its operands, iterates subtractions using the datapath compare flags, and returns the result with a one-cycle done pulse to the owner.
- Handles zero operands and has an iteration watchdog.

Parameters:
- W, 8, operand/result width
- NREQ, 4, number of requesters (>=2)
- MAX_ITER, 2**W, subtraction limit before error abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level
- opa  in  NREQ*W  packed operand A per requester (slice i = requester i)
- opb  in  NREQ*W  packed operand B per requester
- gnt  out  NREQ  one-hot grant, held for the whole operation
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner
- result  out  W  GCD value, valid while any done bit is high
- err  out  1  watchdog abort flag, valid with done
- din  out  W  operand bus to datapath input mux
- sel_sub  out  1  datapath input mux: 0 = din, 1 = subtractor output
- ld_a  out  1  load register A
- ld_b  out  1  load register B
- sub_dir  out  1  0 = A-B, 1 = B-A
- a_q  in  W  datapath register A
- b_q  in  W  datapath register B
- lt, gt, eq  in  1 each  datapath compare flags (A<B, A>B, A==B); combinational on a_q/b_q

Behaviour:
- Reset (async, mid-operation included):
  - state=IDLE, gnt=0, done=0, result=0, err=0, rr pointer=0, iteration counter=0.
  - All datapath controls are 0.
  - An aborted operation produces no done pulse.
- States: IDLE, LOAD_A, LOAD_B, ITER, DONE.
- Datapath controls are combinational from state, plus eq/lt/gt in ITER. Everything else is registered.
- IDLE:
  - If any req is high, the arbiter picks the first requester at or after the rr pointer (wrapping).
  - Registered: owner index, gnt, counter cleared. Next state LOAD_A.
  - No req: stay in IDLE.
- LOAD_A: din=opa[owner], sel_sub=0, ld_a=1. Next state LOAD_B.
- LOAD_B: din=opb[owner], sel_sub=0, ld_b=1. Next state ITER.
- ITER, evaluated in priority order:
  1. a_q==0 or b_q==0: result<=a_q|b_q, go to DONE. gcd(0,0)=0, err=0.
  2. eq: result<=a_q, go to DONE.
  3. counter==MAX_ITER: result<=0, err<=1, go to DONE.
  4. gt: sel_sub=1, sub_dir=0, ld_a=1, counter+1, stay in ITER.
  5. lt: sel_sub=1, sub_dir=1, ld_b=1, counter+1, stay in ITER.
- DONE:
  - done[owner]=1 for exactly one cycle; result/err valid.
  - rr pointer <= (owner+1) mod NREQ. Next state IDLE, where gnt clears.
  - err clears on the next grant.
- Latency: with k subtractions, done is high 4+k cycles after the cycle in which req was sampled in IDLE.
  - Minimum back-to-back turnaround: one IDLE cycle between operations.
- Requester rules:
  - Must hold opa/opb stable while gnt is high.
  - Dropping req during an operation does not abort it; done still pulses.
  - req is ignored except in IDLE.
- Simultaneous requests are resolved purely by the rr pointer. Starvation-free: each requester waits at most NREQ-1 operations.
- Counter width: $clog2(MAX_ITER+1). Never wraps; the watchdog catches the limit first.

Decomposition:
- Package gcd_pkg holds:
  - state enum and encoding (IDLE=0 .. DONE=4)
  - SUB_A_MINUS_B/SUB_B_MINUS_A constants for sub_dir
  - SEL_DIN/SEL_SUB constants
- Sub-module gcd_rr_arb: combinational round-robin pick.
  - Inputs: req, ptr.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Single requester 0, A=12, B=8, req sampled cycle 0 -> ld_a cycle 1, ld_b cycle 2, subtractions cycles 3-4, done[0] and result=4 in cycle 6, err=0.
- All 4 req high continuously, distinct operands -> grants in order 0,1,2,3,0. Each done is one-hot and matches the gnt owner. Each result matches the reference gcd.
- Zero operands: (0,9) -> result=9; (15,0) -> 15; (0,0) -> 0. Each completes in 4 cycles with no ld in ITER and err=0.
- W=8, MAX_ITER=5, A=200, B=1 -> err=1 and result=0 with done after 5 subtractions; the next request succeeds with err=0.
- Assert rst during ITER for requester 2 -> outputs zero immediately and no done[2]. After release, requester 1 (pointer reset to 0) is served first if both requesters 1 and 2 request.
- Owner drops req mid-ITER with A=255, B=1 -> operation completes, result=1, done pulses once.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and encodings for the GCD scheduler: FSM states and
// datapath mux/subtract-direction codes.
package gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ITER   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic SUB_A_MINUS_B = 1'b0;
    localparam logic SUB_B_MINUS_A = 1'b1;

    localparam logic SEL_DIN = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping around.
module gcd_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int w_idx;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Time-shares one subtractive-GCD datapath among NREQ requesters with
// round-robin arbitration, zero-operand shortcut and an iteration watchdog.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int W        = 8,
    parameter int NREQ     = 4,
    parameter int MAX_ITER = 2**W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              err,
    output logic [W-1:0]      din,
    output logic              sel_sub,
    output logic              ld_a,
    output logic              ld_b,
    output logic              sub_dir,
    input  logic [W-1:0]      a_q,
    input  logic [W-1:0]      b_q,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_ITER + 1);

    state_t          r_state, w_next;
    logic [IW-1:0]   r_owner, r_ptr, w_arb_idx;
    logic [NREQ-1:0] r_gnt, r_done, w_arb_gnt;
    logic            w_arb_any;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_result;
    logic            r_err;
    logic            w_zero, w_limit, w_step;
    logic [W-1:0]    w_opa, w_opb;

    gcd_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_opa   = opa[r_owner*W +: W];
    assign w_opb   = opb[r_owner*W +: W];
    assign w_zero  = (a_q == '0) || (b_q == '0);
    assign w_limit = (r_cnt == CW'(MAX_ITER));
    // Counting every non-terminating ITER cycle keeps the watchdog live even
    // if the compare flags are inconsistent.
    assign w_step  = !w_zero && !eq && !w_limit;

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;

    always_comb begin
        w_next  = r_state;
        din     = '0;
        sel_sub = SEL_DIN;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        sub_dir = SUB_A_MINUS_B;
        case (r_state)
            ST_IDLE: if (w_arb_any) w_next = ST_LOAD_A;
            ST_LOAD_A: begin
                din    = w_opa;
                ld_a   = 1'b1;
                w_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                din    = w_opb;
                ld_b   = 1'b1;
                w_next = ST_ITER;
            end
            ST_ITER: begin
                if (!w_step) begin
                    w_next = ST_DONE;
                end else if (gt) begin
                    sel_sub = SEL_SUB;
                    ld_a    = 1'b1;
                end else if (lt) begin
                    sel_sub = SEL_SUB;
                    sub_dir = SUB_B_MINUS_A;
                    ld_b    = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_owner <= w_arb_idx;
                        r_gnt   <= w_arb_gnt;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (w_zero) begin
                        r_result <= a_q | b_q;
                    end else if (eq) begin
                        r_result <= a_q;
                    end else if (w_limit) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (!w_step) r_done <= r_gnt;
                end
                ST_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler: behavioural datapath models for a default
// instance and a MAX_ITER=5 instance, with hand-computed expectations.
module tb_gcd_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, wreq = '0;
    logic [31:0] opa = '0, opb = '0;

    logic [3:0] gnt, done;
    logic [7:0] result, din;
    logic       err, sel_sub, ld_a, ld_b, sub_dir;
    logic [7:0] a_q = '0, b_q = '0;
    logic       lt, gt, eq;

    logic [3:0] wd_gnt, wd_done;
    logic [7:0] wd_result, wd_din;
    logic       wd_err, wd_sel, wd_lda, wd_ldb, wd_dir;
    logic [7:0] wd_aq = '0, wd_bq = '0;
    logic       wd_lt, wd_gt, wd_eq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_scheduler #(.W(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .din(din), .sel_sub(sel_sub), .ld_a(ld_a), .ld_b(ld_b), .sub_dir(sub_dir),
        .a_q(a_q), .b_q(b_q), .lt(lt), .gt(gt), .eq(eq)
    );

    gcd_scheduler #(.W(8), .NREQ(4), .MAX_ITER(5)) u_wd (
        .clk(clk), .rst(rst), .req(wreq), .opa(opa), .opb(opb),
        .gnt(wd_gnt), .done(wd_done), .result(wd_result), .err(wd_err),
        .din(wd_din), .sel_sub(wd_sel), .ld_a(wd_lda), .ld_b(wd_ldb), .sub_dir(wd_dir),
        .a_q(wd_aq), .b_q(wd_bq), .lt(wd_lt), .gt(wd_gt), .eq(wd_eq)
    );

    // Datapath models: registers A/B, subtractor, input mux, comparator.
    always @(posedge clk) begin
        if (ld_a) a_q <= sel_sub ? (sub_dir ? b_q - a_q : a_q - b_q) : din;
        if (ld_b) b_q <= sel_sub ? (sub_dir ? b_q - a_q : a_q - b_q) : din;
        if (wd_lda) wd_aq <= wd_sel ? (wd_dir ? wd_bq - wd_aq : wd_aq - wd_bq) : wd_din;
        if (wd_ldb) wd_bq <= wd_sel ? (wd_dir ? wd_bq - wd_aq : wd_aq - wd_bq) : wd_din;
    end
    assign lt = a_q < b_q;
    assign gt = a_q > b_q;
    assign eq = a_q == b_q;
    assign wd_lt = wd_aq < wd_bq;
    assign wd_gt = wd_aq > wd_bq;
    assign wd_eq = wd_aq == wd_bq;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit use_wd, input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            tick();
            cyc++;
            if ((use_wd ? wd_done : done) != 4'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++; if ({gnt, done, result, err} !== 17'd0) begin n_err++; $display("FAIL reset_outputs: got %h required 0", {gnt, done, result, err}); end
        n_cmp++; if ({din, sel_sub, ld_a, ld_b, sub_dir} !== 12'd0) begin n_err++; $display("FAIL reset_ctrl: got %h required 0", {din, sel_sub, ld_a, ld_b, sub_dir}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        opa[7:0] = 8'd12; opb[7:0] = 8'd8; req = 4'b0001;
        tick();
        req = 4'b0;
        n_cmp++; if ({gnt, ld_a, ld_b, sel_sub, din} !== {4'b0001, 3'b100, 8'd12}) begin n_err++; $display("FAIL single_load_a: got %h required %h", {gnt, ld_a, ld_b, sel_sub, din}, {4'b0001, 3'b100, 8'd12}); end
        tick();
        n_cmp++; if ({ld_a, ld_b, sel_sub, din} !== {3'b010, 8'd8}) begin n_err++; $display("FAIL single_load_b: got %h required %h", {ld_a, ld_b, sel_sub, din}, {3'b010, 8'd8}); end
        tick();
        n_cmp++; if ({ld_a, ld_b, sel_sub, sub_dir} !== 4'b1010) begin n_err++; $display("FAIL single_sub1: got %b required 1010", {ld_a, ld_b, sel_sub, sub_dir}); end
        tick();
        n_cmp++; if ({ld_a, ld_b, sel_sub, sub_dir} !== 4'b0111) begin n_err++; $display("FAIL single_sub2: got %b required 0111", {ld_a, ld_b, sel_sub, sub_dir}); end
        tick();
        n_cmp++; if ({ld_a, ld_b, done} !== 6'd0) begin n_err++; $display("FAIL single_eq_cycle: got %b required 0", {ld_a, ld_b, done}); end
        tick();
        n_cmp++; if ({done, result, err} !== {4'b0001, 8'd4, 1'b0}) begin n_err++; $display("FAIL single_done: got %h required %h", {done, result, err}, {4'b0001, 8'd4, 1'b0}); end
        tick();
        n_cmp++; if ({done, gnt} !== 8'd0) begin n_err++; $display("FAIL single_after: got %h required 0", {done, gnt}); end
    endtask

    task automatic test_zero();
        logic [7:0] za [3] = '{8'd0, 8'd15, 8'd0};
        logic [7:0] zb [3] = '{8'd9, 8'd0, 8'd0};
        logic [7:0] zr [3] = '{8'd9, 8'd15, 8'd0};
        for (int i = 0; i < 3; i++) begin
            opa[7:0] = za[i]; opb[7:0] = zb[i]; req = 4'b0001;
            tick();
            req = 4'b0;
            tick();
            tick();
            n_cmp++; if ({ld_a, ld_b} !== 2'b00) begin n_err++; $display("FAIL zero_no_ld[%0d]: got %b required 00", i, {ld_a, ld_b}); end
            tick();
            n_cmp++; if ({done, result, err} !== {4'b0001, zr[i], 1'b0}) begin n_err++; $display("FAIL zero_done[%0d]: got %h required %h", i, {done, result, err}, {4'b0001, zr[i], 1'b0}); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rr [4] = '{8'd4, 8'd3, 8'd1, 8'd10};
        int cyc;
        bit ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        opa = {8'd10, 8'd7, 8'd9, 8'd12};
        opb = {8'd10, 8'd5, 8'd6, 8'd8};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(1'b0, 40, cyc, ok);
            if (i == 4) req = 4'b0;
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout[%0d]: got no done within 40 cycles required done", i); end
            n_cmp++; if ({done, gnt} !== {4'(1 << (i % 4)), 4'(1 << (i % 4))}) begin n_err++; $display("FAIL rr_owner[%0d]: got done=%b gnt=%b required %b", i, done, gnt, 4'(1 << (i % 4))); end
            n_cmp++; if ({result, err} !== {exp_rr[i % 4], 1'b0}) begin n_err++; $display("FAIL rr_result[%0d]: got %0d err=%b required %0d", i, result, err, exp_rr[i % 4]); end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        logic [3:0] seen;
        opa = {8'd0, 8'd255, 8'd8, 8'd0};
        opb = {8'd0, 8'd1, 8'd12, 8'd0};
        req = 4'b0100;
        repeat (5) tick();
        n_cmp++; if ({gnt, ld_a} !== 5'b01001) begin n_err++; $display("FAIL mid_pre: got %b required 01001", {gnt, ld_a}); end
        req = 4'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if ({gnt, done, result, err, din, sel_sub, ld_a, ld_b, sub_dir} !== 29'd0) begin n_err++; $display("FAIL mid_reset: got %h required 0", {gnt, done, result, err, din, sel_sub, ld_a, ld_b, sub_dir}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = '0;
        repeat (4) begin tick(); seen |= done; end
        n_cmp++; if (seen !== 4'b0) begin n_err++; $display("FAIL mid_no_done: got %b required 0000", seen); end
        req = 4'b0110;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_first_gnt: got %b required 0010", gnt); end
        wait_done(1'b0, 40, cyc, ok);
        n_cmp++; if ({ok, done, result} !== {1'b1, 4'b0010, 8'd4}) begin n_err++; $display("FAIL mid_req1: got ok=%b done=%b res=%0d required 1 0010 4", ok, done, result); end
        wait_done(1'b0, 400, cyc, ok);
        req = 4'b0;
        n_cmp++; if ({ok, done, result} !== {1'b1, 4'b0100, 8'd1}) begin n_err++; $display("FAIL mid_req2: got ok=%b done=%b res=%0d required 1 0100 1", ok, done, result); end
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int cyc;
        bit ok;
        opa[7:0] = 8'd200; opb[7:0] = 8'd1; wreq = 4'b0001;
        wait_done(1'b1, 60, cyc, ok);
        wreq = 4'b0;
        n_cmp++; if ({ok, cyc} !== {1'b1, 32'd9}) begin n_err++; $display("FAIL wd_latency: got ok=%b cycles=%0d required 1 9", ok, cyc); end
        n_cmp++; if ({wd_done, wd_gnt, wd_result, wd_err} !== {4'b0001, 4'b0001, 8'd0, 1'b1}) begin n_err++; $display("FAIL wd_abort: got done=%b gnt=%b res=%0d err=%b required 0001 0001 0 1", wd_done, wd_gnt, wd_result, wd_err); end
        tick();
        opa[7:0] = 8'd6; opb[7:0] = 8'd4; wreq = 4'b0001;
        tick();
        n_cmp++; if (wd_err !== 1'b0) begin n_err++; $display("FAIL wd_err_clear: got %b required 0", wd_err); end
        wait_done(1'b1, 40, cyc, ok);
        wreq = 4'b0;
        n_cmp++; if ({ok, cyc, wd_result, wd_err} !== {1'b1, 32'd5, 8'd2, 1'b0}) begin n_err++; $display("FAIL wd_next: got ok=%b cycles=%0d res=%0d err=%b required 1 5 2 0", ok, cyc, wd_result, wd_err); end
        tick();
        tick();
    endtask

    task automatic test_drop_req();
        int cyc;
        bit ok;
        logic [3:0] seen;
        opa[31:24] = 8'd255; opb[31:24] = 8'd1; req = 4'b1000;
        repeat (5) tick();
        req = 4'b0;
        wait_done(1'b0, 400, cyc, ok);
        n_cmp++; if ({ok, cyc + 5} !== {1'b1, 32'd258}) begin n_err++; $display("FAIL drop_latency: got ok=%b cycles=%0d required 1 258", ok, cyc + 5); end
        n_cmp++; if ({done, result, err} !== {4'b1000, 8'd1, 1'b0}) begin n_err++; $display("FAIL drop_done: got done=%b res=%0d err=%b required 1000 1 0", done, result, err); end
        seen = '0;
        repeat (4) begin tick(); seen |= done; end
        n_cmp++; if (seen !== 4'b0) begin n_err++; $display("FAIL drop_once: got %b required 0000", seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_reset_mid();
        test_watchdog();
        test_drop_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish required finish within 300us");
        $fatal(1, "timeout");
    end

endmodule
